// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with stall request and result strobe.
module ex_muldiv_seq #(
  parameter int unsigned XLEN         = 32,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int unsigned DW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_next;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      f3_q;
  logic            neg_q;
  logic            rneg_q;
  logic [XLEN-1:0] mag_q;
  logic [DW-1:0]   acc_q;

  logic            accept, finish;

  // Operand decode for the incoming request
  logic            in_div, in_sa, in_sb, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    in_div   = funct3[2];
    in_sa    = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    in_sb    = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    a_neg    = in_sa & op_a[XLEN-1];
    b_neg    = in_sb & op_b[XLEN-1];
    a_mag    = a_neg ? (XLEN'(0) - op_a) : op_a;
    b_mag    = b_neg ? (XLEN'(0) - op_b) : op_b;
    div_zero = in_div & (op_b == '0);
    div_ovf  = in_div & ~funct3[0] & (op_a == MIN_NEG) & (&op_b);
    fast     = FAST_SPECIAL & (div_zero | div_ovf);
    if (div_zero) begin
      spec_res = funct3[1] ? op_a : '1;
    end else begin
      spec_res = funct3[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration of multiply or restoring divide on the accumulator
  logic [XLEN:0]   mul_sum, div_trial;
  logic [DW-1:0]   mul_next, div_next, acc_step;
  logic [DW-1:0]   prod_s;
  logic [XLEN-1:0] quo_s, rem_s, calc_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[DW-1:XLEN]} + {1'b0, (acc_q[0] ? mag_q : '0)};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = acc_q[DW-1:XLEN-1] - {1'b0, mag_q};
    if (div_trial[XLEN]) begin
      div_next = {acc_q[DW-2:0], 1'b0};
    end else begin
      div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    acc_step = f3_q[2] ? div_next : mul_next;

    prod_s = neg_q  ? (DW'(0) - acc_step) : acc_step;
    quo_s  = neg_q  ? (XLEN'(0) - acc_step[XLEN-1:0]) : acc_step[XLEN-1:0];
    rem_s  = rneg_q ? (XLEN'(0) - acc_step[DW-1:XLEN]) : acc_step[DW-1:XLEN];
    if (f3_q[2]) begin
      calc_res = f3_q[1] ? rem_s : quo_s;
    end else begin
      calc_res = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[DW-1:XLEN];
    end
  end

  // Next-state and combinational control
  always_comb begin
    state_next = state_q;
    accept     = 1'b0;
    finish     = 1'b0;
    stall_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          accept     = 1'b1;
          stall_req  = 1'b1;
          state_next = fast ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        stall_req = 1'b1;
        if (flush) begin
          state_next = S_IDLE;
        end else if (cnt_q == '0) begin
          finish     = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      f3_q         <= '0;
      neg_q        <= 1'b0;
      rneg_q       <= 1'b0;
      mag_q        <= '0;
      acc_q        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      state_q      <= state_next;
      busy         <= (state_next != S_IDLE);
      result_valid <= (state_next == S_DONE);
      if (accept) begin
        f3_q   <= funct3;
        cnt_q  <= CNT_LAST;
        rneg_q <= a_neg;
        if (in_div) begin
          // Divisor zero keeps the all-ones quotient unsigned
          neg_q <= (a_neg ^ b_neg) & (op_b != '0);
          mag_q <= b_mag;
          acc_q <= {{XLEN{1'b0}}, a_mag};
        end else begin
          neg_q <= a_neg ^ b_neg;
          mag_q <= a_mag;
          acc_q <= {{XLEN{1'b0}}, b_mag};
        end
        if (fast) begin
          result <= spec_res;
        end
      end else if (state_q == S_CALC && !flush) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - CW'(1);
        if (finish) begin
          result <= calc_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed RV32M cases, special
// cases, flush/start collisions, mid-op reset and randomized ops vs a model.
module tb_ex_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        result_valid;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  ex_muldiv_seq #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy),
    .stall_req(stall_req), .result_valid(result_valid), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RV32M semantics via 64-bit integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (f)
      3'b000: begin p = sa * sb; return p[31:0];  end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'b101: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'b110: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait (bounded) for its strobe; ends in the following IDLE cycle
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int stalls,
                       output logic busy_after);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    lat = 0; stalls = 0; res = '0; busy_after = 1'b1;
    #1;
    if (stall_req) stalls++;
    step();
    start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (result_valid) begin
        lat = i;
        res = result;
        if (stall_req) stalls += 100;
        break;
      end
      if (stall_req) stalls++;
      step();
    end
    if (lat != 0) begin
      step();
      busy_after = busy;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    step(); step();
    n_checks += 4;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    if (result_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", result_valid); else n_pass++;
    if (result !== 32'd0) $display("FAIL reset_result: got %h expected 0", result); else n_pass++;
    if (stall_req !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_req); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat, st; logic ba;
    logic [2:0]  f  [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] a  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], r, lat, st, ba);
      n_checks += 4;
      if (r !== ex[i]) $display("FAIL mul_result[%0d]: got %h expected %h", i, r, ex[i]); else n_pass++;
      if (lat != 33) $display("FAIL mul_latency[%0d]: got %0d expected 33", i, lat); else n_pass++;
      if (st != 33) $display("FAIL mul_stall_cycles[%0d]: got %0d expected 33", i, st); else n_pass++;
      if (ba !== 1'b0) $display("FAIL mul_busy_after[%0d]: got %b expected 0", i, ba); else n_pass++;
    end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat, st; logic ba;
    logic [2:0]  f  [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] a  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                           32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b  [8] = '{32'd2, 32'd2, 32'd7, 32'd7,
                           32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                           32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0};
    int          el [8] = '{33, 33, 33, 33, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      do_op(f[i], a[i], b[i], r, lat, st, ba);
      n_checks += 2;
      if (r !== ex[i]) $display("FAIL div_result[%0d]: got %h expected %h", i, r, ex[i]); else n_pass++;
      if (lat != el[i]) $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lat, el[i]); else n_pass++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] r, a, b; logic [2:0] f; int lat, st; logic ba;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op(f, a, b, r, lat, st, ba);
      n_checks += 2;
      if (r !== model(f, a, b))
        $display("FAIL rand_result[%0d] f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, r, model(f, a, b));
      else n_pass++;
      if (lat != model_lat(f, a, b))
        $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, model_lat(f, a, b));
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, r; int lat, st, seen; logic ba;
    prev = result;
    seen = 0;
    funct3 = 3'b000; op_a = 32'd1234; op_b = 32'd5678; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (result_valid) seen++;
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks += 4;
    if (busy !== 1'b0) $display("FAIL flush_busy: got %b expected 0", busy); else n_pass++;
    if (result_valid !== 1'b0 || seen != 0)
      $display("FAIL flush_no_strobe: got %b/%0d expected 0/0", result_valid, seen); else n_pass++;
    if (result !== prev) $display("FAIL flush_result_held: got %h expected %h", result, prev); else n_pass++;
    do_op(3'b101, 32'd9, 32'd3, r, lat, st, ba);
    if (r !== 32'd3 || lat != 33)
      $display("FAIL flush_restart: got %h/%0d expected 00000003/33", r, lat); else n_pass++;

    // start together with flush in IDLE must not be accepted
    prev = result;
    seen = 0;
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; start = 1'b1; flush = 1'b1;
    #1;
    n_checks += 3;
    if (stall_req !== 1'b0) $display("FAIL start_flush_stall: got %b expected 0", stall_req); else n_pass++;
    step();
    start = 1'b0; flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid || busy) seen++;
      step();
    end
    if (seen != 0) $display("FAIL start_flush_ignored: got %0d active cycles expected 0", seen); else n_pass++;
    if (result !== prev) $display("FAIL start_flush_result: got %h expected %h", result, prev); else n_pass++;
  endtask

  // start held high through CALC and DONE: ignored until the next IDLE cycle
  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, r1, r2; int lat1, lat2;
    a1 = 32'($urandom); b1 = 32'($urandom) | 32'd1;
    a2 = 32'($urandom); b2 = 32'($urandom_range(1, 1000));
    lat1 = 0; lat2 = 0; r1 = '0; r2 = '0;
    funct3 = 3'b001; op_a = a1; op_b = b1; start = 1'b1;
    step();
    funct3 = 3'b110; op_a = a2; op_b = b2;
    for (int i = 1; i <= 60; i++) begin
      if (result_valid) begin lat1 = i; r1 = result; break; end
      step();
    end
    step();
    n_checks += 5;
    if (stall_req !== 1'b1) $display("FAIL b2b_accept_stall: got %b expected 1", stall_req); else n_pass++;
    step();
    start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (result_valid) begin lat2 = i; r2 = result; break; end
      step();
    end
    step();
    if (r1 !== model(3'b001, a1, b1)) $display("FAIL b2b_first: got %h expected %h", r1, model(3'b001, a1, b1)); else n_pass++;
    if (lat1 != 33) $display("FAIL b2b_first_lat: got %0d expected 33", lat1); else n_pass++;
    if (r2 !== model(3'b110, a2, b2)) $display("FAIL b2b_second: got %h expected %h", r2, model(3'b110, a2, b2)); else n_pass++;
    if (lat2 != 33) $display("FAIL b2b_second_lat: got %0d expected 33", lat2); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat, st, seen; logic ba;
    seen = 0;
    funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    n_checks += 6;
    if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
    if (result_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", result_valid); else n_pass++;
    if (result !== 32'd0) $display("FAIL midrst_result: got %h expected 0", result); else n_pass++;
    if (stall_req !== 1'b0) $display("FAIL midrst_stall: got %b expected 0", stall_req); else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 35; i++) begin
      if (result_valid) seen++;
      step();
    end
    if (seen != 0) $display("FAIL midrst_no_strobe: got %0d expected 0", seen); else n_pass++;
    do_op(3'b111, 32'd1000, 32'd7, r, lat, st, ba);
    if (r !== 32'd6 || lat != 33)
      $display("FAIL midrst_recover: got %h/%0d expected 00000006/33", r, lat); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
